tagged_regfile: RTL

Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit port.
- The decoder/dispatch stage marks a destination register busy with its ROB tag.
- The ROB commit port writes the retired value and releases the tag.
- Source reads return either a committed value or the ROB tag the consumer must wait on.

---
 rtl/tagged_regfile.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/tagged_regfile.sv
// -----------------------------------------------------------------------------
// tagged_regfile
//   Architectural register file with per-register rename tags, fed by the
//   reorder buffer commit port. Dispatch marks a destination busy with its
//   ROB tag; commit writes the retired value and releases the tag if it is
//   still the newest producer; reads return either the committed value or
//   the tag the consumer has to wait on.
//
//   Optional build macro: TREG_COMMIT_BYPASS_EN
//     When defined, a read whose register is being released by this cycle's
//     commit sees the committed value (busy 0, tag 0) in the same cycle.
//     When undefined, reads always reflect registered state.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            clears all busy/tag state, drops same-cycle dispatch
//   dispatch_*       rename of a destination register to a ROB tag
//   commit_*         retirement of a register-writing instruction
//   rs1_*, rs2_*     combinational source reads (val, pending tag, busy)
//   busy_count       registered popcount of busy registers
// -----------------------------------------------------------------------------
module tagged_regfile #(
  parameter int TAG_W    = 4,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_rd,
  input  logic [TAG_W-1:0] dispatch_tag,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [31:0]      commit_val,
  input  logic [4:0]       rs1_idx,
  input  logic [4:0]       rs2_idx,
  output logic [31:0]      rs1_val,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs1_busy,
  output logic [31:0]      rs2_val,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs2_busy,
  output logic [5:0]       busy_count
);

  logic [31:0]         val_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [TAG_W-1:0]    tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [5:0]          count_d;

  logic disp_en;
  logic commit_en;
  logic release_en;

  // Qualified events. A commit only releases the register when it is still
  // the newest producer and no same-cycle rename replaces it.
  always_comb begin
    disp_en    = dispatch_valid && (dispatch_rd != '0) && (dispatch_tag != '0) && !flush;
    commit_en  = commit_valid && (commit_rd != '0);
    release_en = commit_en && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag)
                 && (commit_tag != '0) && !(disp_en && (dispatch_rd == commit_rd));
  end

  // Next busy/tag state and its popcount
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) tag_d[i] = tag_q[i];

    if (flush) begin
      busy_d = '0;
      for (int i = 0; i < NUM_REGS; i++) tag_d[i] = '0;
    end else begin
      if (release_en) begin
        busy_d[commit_rd] = 1'b0;
        tag_d[commit_rd]  = '0;
      end
      if (disp_en) begin
        busy_d[dispatch_rd] = 1'b1;
        tag_d[dispatch_rd]  = dispatch_tag;
      end
    end
    // x0 never holds a rename
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;

    count_d = '0;
    for (int i = 1; i < NUM_REGS; i++) count_d = count_d + 6'(busy_d[i]);
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        tag_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
      for (int i = 0; i < NUM_REGS; i++) tag_q[i] <= tag_d[i];
      // Values are written even in a flush cycle or on a stale-tag commit
      if (commit_en) val_q[commit_rd] <= commit_val;
    end
  end

  // Source reads: zero-latency from registered state
  always_comb begin
    rs1_val  = val_q[rs1_idx];
    rs1_busy = busy_q[rs1_idx];
    rs1_tag  = busy_q[rs1_idx] ? tag_q[rs1_idx] : '0;
    rs2_val  = val_q[rs2_idx];
    rs2_busy = busy_q[rs2_idx];
    rs2_tag  = busy_q[rs2_idx] ? tag_q[rs2_idx] : '0;

    if (rs1_idx == '0) begin
      rs1_val  = '0;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
    end
    if (rs2_idx == '0) begin
      rs2_val  = '0;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
    end

`ifdef TREG_COMMIT_BYPASS_EN
    // Forward a releasing commit straight to the consumer
    if (commit_valid && (rs1_idx == commit_rd) && (rs1_idx != '0) &&
        busy_q[rs1_idx] && (tag_q[rs1_idx] == commit_tag)) begin
      rs1_val  = commit_val;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
    end
    if (commit_valid && (rs2_idx == commit_rd) && (rs2_idx != '0) &&
        busy_q[rs2_idx] && (tag_q[rs2_idx] == commit_tag)) begin
      rs2_val  = commit_val;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
    end
`endif
  end

endmodule
